// File: rtl/cfe_wait_scheduler.sv
// Consumer end of the CFE feedback-wait loop: counts down the fed-back wait,
// pulses the estimator start, then collects its frequency-offset result or times out.
module cfe_wait_scheduler #(
    parameter int CFE_NBW_FO  = 13,
    parameter int CFE_NBW_LAT = 32,
    parameter int CFE_TIMEOUT = 1024,
    parameter int CFE_SETTLE  = 2
) (
    input  logic                   clk,
    input  logic                   rst_async_n,
    input  logic                   i_enable,
    input  logic [CFE_NBW_LAT-1:0] i_wait,
    input  logic                   i_cfe_done,
    input  logic [CFE_NBW_FO-1:0]  i_fo_value,
    output logic                   o_cfe_start,
    output logic                   o_fo_valid,
    output logic [CFE_NBW_FO-1:0]  o_fo_value,
    output logic                   o_timeout,
    output logic                   o_busy,
    output logic [15:0]            o_trig_cnt,
    output logic [15:0]            o_tmo_cnt
);

    localparam int TMO_W  = $clog2(CFE_TIMEOUT);
    localparam int HOLD_W = (CFE_SETTLE > 1) ? $clog2(CFE_SETTLE) : 1;

    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(CFE_TIMEOUT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CFE_SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RUN,
        HOLD
    } state_t;

    state_t                 state;
    logic [CFE_NBW_LAT-1:0] wait_cnt;
    logic [TMO_W-1:0]       tmo_cnt;
    logic [HOLD_W-1:0]      hold_cnt;

    // A zero wait is treated as one so the start pulse always follows a WAIT cycle.
    function automatic logic [CFE_NBW_LAT-1:0] wait_load(input logic [CFE_NBW_LAT-1:0] w);
        return (w == '0) ? CFE_NBW_LAT'(1) : w;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            tmo_cnt     <= '0;
            hold_cnt    <= '0;
            o_cfe_start <= 1'b0;
            o_fo_valid  <= 1'b0;
            o_fo_value  <= '0;
            o_timeout   <= 1'b0;
            o_busy      <= 1'b0;
            o_trig_cnt  <= '0;
            o_tmo_cnt   <= '0;
        end else begin
            o_cfe_start <= 1'b0;
            o_fo_valid  <= 1'b0;
            o_timeout   <= 1'b0;

            // Disable outranks every event, including a done on the same edge.
            if (!i_enable) begin
                state    <= IDLE;
                wait_cnt <= '0;
                tmo_cnt  <= '0;
                hold_cnt <= '0;
                o_busy   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        wait_cnt <= wait_load(i_wait);
                        state    <= WAIT;
                    end
                    WAIT: begin
                        if (wait_cnt > CFE_NBW_LAT'(1)) begin
                            wait_cnt <= wait_cnt - CFE_NBW_LAT'(1);
                        end else begin
                            o_cfe_start <= 1'b1;
                            tmo_cnt     <= '0;
                            o_trig_cnt  <= o_trig_cnt + 16'd1;
                            o_busy      <= 1'b1;
                            state       <= RUN;
                        end
                    end
                    RUN: begin
                        // Done checked first so it wins on the timeout edge.
                        if (i_cfe_done) begin
                            o_fo_value <= i_fo_value;
                            o_fo_valid <= 1'b1;
                            hold_cnt   <= '0;
                            o_busy     <= 1'b0;
                            state      <= HOLD;
                        end else if (tmo_cnt == TMO_LAST) begin
                            o_timeout <= 1'b1;
                            o_tmo_cnt <= sat_inc16(o_tmo_cnt);
                            hold_cnt  <= '0;
                            o_busy    <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end
                    HOLD: begin
                        // Give the feedback logic time to publish a fresh i_wait.
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                        if (hold_cnt == HOLD_LAST) begin
                            wait_cnt <= wait_load(i_wait);
                            state    <= WAIT;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cfe_wait_scheduler.sv
// Directed bench for cfe_wait_scheduler: loop timing, wait edge cases, timeout,
// done/timeout and disable/done races, async reset and counter saturation/wrap.
module tb_cfe_wait_scheduler;

    logic        clk = 1'b0;
    logic        rst_async_n;
    logic        i_enable;
    logic [31:0] i_wait;
    logic        i_cfe_done;
    logic [12:0] i_fo_value;
    logic        o_cfe_start;
    logic        o_fo_valid;
    logic [12:0] o_fo_value;
    logic        o_timeout;
    logic        o_busy;
    logic [15:0] o_trig_cnt;
    logic [15:0] o_tmo_cnt;

    int checks = 0;
    int errors = 0;
    int exp_trig = 0;

    always #5 clk = ~clk;

    cfe_wait_scheduler #(
        .CFE_NBW_FO (13),
        .CFE_NBW_LAT(32),
        .CFE_TIMEOUT(16),
        .CFE_SETTLE (2)
    ) dut (
        .clk        (clk),
        .rst_async_n(rst_async_n),
        .i_enable   (i_enable),
        .i_wait     (i_wait),
        .i_cfe_done (i_cfe_done),
        .i_fo_value (i_fo_value),
        .o_cfe_start(o_cfe_start),
        .o_fo_valid (o_fo_valid),
        .o_fo_value (o_fo_value),
        .o_timeout  (o_timeout),
        .o_busy     (o_busy),
        .o_trig_cnt (o_trig_cnt),
        .o_tmo_cnt  (o_tmo_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until o_cfe_start is seen, giving up after limit edges.
    task automatic run_to_start(input int limit, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (o_cfe_start !== 1'b1 && cyc < limit);
    endtask

    task automatic test_reset();
        rst_async_n = 1'b0;
        i_enable    = 1'b0;
        i_wait      = '0;
        i_cfe_done  = 1'b0;
        i_fo_value  = '0;
        repeat (3) tick();
        checks++;
        if ({o_cfe_start, o_fo_valid, o_timeout, o_busy} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b required 0000", {o_cfe_start, o_fo_valid, o_timeout, o_busy});
        end
        checks++;
        if ({o_fo_value, o_trig_cnt, o_tmo_cnt} !== 45'd0) begin
            errors++;
            $display("FAIL reset_values: fo=%h trig=%h tmo=%h required all 0", o_fo_value, o_trig_cnt, o_tmo_cnt);
        end
        rst_async_n = 1'b1;
        repeat (2) tick();
        checks++;
        if ({o_cfe_start, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL idle_disabled: start/busy=%b required 00", {o_cfe_start, o_busy});
        end
    endtask

    task automatic test_basic_loop();
        int cyc;
        i_wait   = 32'h100;
        i_enable = 1'b1;
        run_to_start(400, cyc);
        exp_trig++;
        checks++;
        if (cyc !== 257) begin
            errors++;
            $display("FAIL basic_first_start: edges=%0d required 257", cyc);
        end
        checks++;
        if (o_busy !== 1'b1 || o_trig_cnt !== 16'(exp_trig)) begin
            errors++;
            $display("FAIL basic_run_entry: busy=%b trig=%0d required 1 %0d", o_busy, o_trig_cnt, exp_trig);
        end
        tick();
        checks++;
        if (o_cfe_start !== 1'b0) begin
            errors++;
            $display("FAIL basic_start_width: start=%b required 0", o_cfe_start);
        end
        repeat (3) tick();
        i_cfe_done = 1'b1;
        i_fo_value = 13'h0123;
        tick();
        i_cfe_done = 1'b0;
        i_fo_value = '0;
        checks++;
        if (o_fo_valid !== 1'b1 || o_fo_value !== 13'h0123 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: valid=%b fo=%h busy=%b required 1 0123 0", o_fo_valid, o_fo_value, o_busy);
        end
        tick();
        checks++;
        if (o_fo_valid !== 1'b0 || o_fo_value !== 13'h0123) begin
            errors++;
            $display("FAIL basic_valid_width: valid=%b fo=%h required 0 0123", o_fo_valid, o_fo_value);
        end
        run_to_start(400, cyc);
        exp_trig++;
        checks++;
        if (cyc + 1 !== 258) begin
            errors++;
            $display("FAIL basic_period: edges after done=%0d required 258", cyc + 1);
        end
        checks++;
        if (o_trig_cnt !== 16'(exp_trig)) begin
            errors++;
            $display("FAIL basic_trig_cnt: got %0d required %0d", o_trig_cnt, exp_trig);
        end
        i_enable = 1'b0;
        tick();
    endtask

    task automatic test_zero_one_wait();
        for (int w = 0; w < 2; w++) begin
            i_wait   = 32'(w);
            i_enable = 1'b1;
            tick();
            checks++;
            if (o_cfe_start !== 1'b0) begin
                errors++;
                $display("FAIL wait%0d_early: start=%b required 0", w, o_cfe_start);
            end
            tick();
            exp_trig++;
            checks++;
            if (o_cfe_start !== 1'b1) begin
                errors++;
                $display("FAIL wait%0d_start: start=%b required 1", w, o_cfe_start);
            end
            i_enable = 1'b0;
            tick();
        end
        checks++;
        if (o_trig_cnt !== 16'(exp_trig)) begin
            errors++;
            $display("FAIL wait01_trig_cnt: got %0d required %0d", o_trig_cnt, exp_trig);
        end
    endtask

    task automatic test_timeout();
        int cyc;
        i_wait   = 32'd3;
        i_enable = 1'b1;
        run_to_start(20, cyc);
        exp_trig++;
        checks++;
        if (cyc !== 4) begin
            errors++;
            $display("FAIL tmo_start: edges=%0d required 4", cyc);
        end
        repeat (15) tick();
        checks++;
        if (o_timeout !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL tmo_early: timeout=%b busy=%b required 0 1", o_timeout, o_busy);
        end
        tick();
        checks++;
        if (o_timeout !== 1'b1 || o_tmo_cnt !== 16'd1 || o_busy !== 1'b0 || o_fo_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_fire: timeout=%b tmo_cnt=%0d busy=%b valid=%b required 1 1 0 0",
                     o_timeout, o_tmo_cnt, o_busy, o_fo_valid);
        end
        checks++;
        if (o_fo_value !== 13'h0123) begin
            errors++;
            $display("FAIL tmo_fo_kept: got %h required 0123", o_fo_value);
        end
        i_cfe_done = 1'b1;
        i_fo_value = 13'h1abc;
        tick();
        checks++;
        if (o_fo_valid !== 1'b0 || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL tmo_late_hold: valid=%b timeout=%b required 0 0", o_fo_valid, o_timeout);
        end
        repeat (2) tick();
        checks++;
        if (o_fo_valid !== 1'b0 || o_fo_value !== 13'h0123) begin
            errors++;
            $display("FAIL tmo_late_wait: valid=%b fo=%h required 0 0123", o_fo_valid, o_fo_value);
        end
        i_cfe_done = 1'b0;
        i_fo_value = '0;
        run_to_start(10, cyc);
        exp_trig++;
        checks++;
        if (cyc !== 2) begin
            errors++;
            $display("FAIL tmo_restart: edges=%0d required 2", cyc);
        end
        i_enable = 1'b0;
        tick();
    endtask

    task automatic test_done_vs_timeout();
        int cyc;
        i_wait   = 32'd2;
        i_enable = 1'b1;
        run_to_start(20, cyc);
        exp_trig++;
        checks++;
        if (cyc !== 3) begin
            errors++;
            $display("FAIL race_start: edges=%0d required 3", cyc);
        end
        repeat (15) tick();
        i_cfe_done = 1'b1;
        i_fo_value = 13'h0555;
        tick();
        i_cfe_done = 1'b0;
        i_fo_value = '0;
        checks++;
        if (o_fo_valid !== 1'b1 || o_timeout !== 1'b0 || o_tmo_cnt !== 16'd1 || o_fo_value !== 13'h0555) begin
            errors++;
            $display("FAIL race_done_wins: valid=%b timeout=%b tmo_cnt=%0d fo=%h required 1 0 1 0555",
                     o_fo_valid, o_timeout, o_tmo_cnt, o_fo_value);
        end
        tick();
        checks++;
        if (o_timeout !== 1'b0 || o_fo_valid !== 1'b0) begin
            errors++;
            $display("FAIL race_after: timeout=%b valid=%b required 0 0", o_timeout, o_fo_valid);
        end
        i_enable = 1'b0;
        tick();
    endtask

    task automatic test_disable_mid_run();
        int cyc;
        i_wait   = 32'd4;
        i_enable = 1'b1;
        run_to_start(20, cyc);
        exp_trig++;
        checks++;
        if (cyc !== 5) begin
            errors++;
            $display("FAIL dis_start: edges=%0d required 5", cyc);
        end
        repeat (2) tick();
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL dis_busy_run: busy=%b required 1", o_busy);
        end
        i_enable   = 1'b0;
        i_cfe_done = 1'b1;
        i_fo_value = 13'h0777;
        tick();
        i_cfe_done = 1'b0;
        i_fo_value = '0;
        checks++;
        if (o_fo_valid !== 1'b0 || o_busy !== 1'b0 || o_timeout !== 1'b0 || o_fo_value !== 13'h0555) begin
            errors++;
            $display("FAIL dis_wins: valid=%b busy=%b timeout=%b fo=%h required 0 0 0 0555",
                     o_fo_valid, o_busy, o_timeout, o_fo_value);
        end
        i_wait   = 32'd6;
        i_enable = 1'b1;
        run_to_start(20, cyc);
        exp_trig++;
        checks++;
        if (cyc !== 7) begin
            errors++;
            $display("FAIL dis_reenable: edges=%0d required 7", cyc);
        end
        checks++;
        if (o_trig_cnt !== 16'(exp_trig) || o_tmo_cnt !== 16'd1) begin
            errors++;
            $display("FAIL dis_counters: trig=%0d tmo=%0d required %0d 1", o_trig_cnt, o_tmo_cnt, exp_trig);
        end
        i_enable = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        int cyc;
        i_wait   = 32'h20;
        i_enable = 1'b1;
        repeat (5) tick();
        #2;
        rst_async_n = 1'b0;
        #1;
        checks++;
        if ({o_cfe_start, o_fo_valid, o_timeout, o_busy} !== 4'b0000 ||
            {o_fo_value, o_trig_cnt, o_tmo_cnt} !== 45'd0) begin
            errors++;
            $display("FAIL async_reset: flags=%b fo=%h trig=%h tmo=%h required all 0",
                     {o_cfe_start, o_fo_valid, o_timeout, o_busy}, o_fo_value, o_trig_cnt, o_tmo_cnt);
        end
        #2;
        rst_async_n = 1'b1;
        exp_trig    = 0;
        run_to_start(60, cyc);
        exp_trig++;
        checks++;
        if (cyc !== 33) begin
            errors++;
            $display("FAIL async_restart: edges=%0d required 33", cyc);
        end
        checks++;
        if (o_trig_cnt !== 16'(exp_trig)) begin
            errors++;
            $display("FAIL async_trig_cnt: got %0d required %0d", o_trig_cnt, exp_trig);
        end
    endtask

    // Entered in RUN on the cycle the start pulse is visible; wait stays 0x20.
    task automatic test_saturation();
        int cyc;
        force dut.o_tmo_cnt = 16'hFFFE;
        tick();
        release dut.o_tmo_cnt;
        cyc = 1;
        do begin
            tick();
            cyc++;
        end while (o_timeout !== 1'b1 && cyc < 40);
        checks++;
        if (cyc !== 16 || o_tmo_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_first: edges=%0d tmo=%h required 16 FFFF", cyc, o_tmo_cnt);
        end
        force dut.o_trig_cnt = 16'hFFFF;
        tick();
        release dut.o_trig_cnt;
        run_to_start(60, cyc);
        checks++;
        if (o_cfe_start !== 1'b1 || o_trig_cnt !== 16'h0000) begin
            errors++;
            $display("FAIL trig_wrap: start=%b trig=%h required 1 0000", o_cfe_start, o_trig_cnt);
        end
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (o_timeout !== 1'b1 && cyc < 40);
        checks++;
        if (o_timeout !== 1'b1 || o_tmo_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: timeout=%b tmo=%h required 1 FFFF", o_timeout, o_tmo_cnt);
        end
        i_enable = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_loop();
        test_zero_one_wait();
        test_timeout();
        test_done_vs_timeout();
        test_disable_mid_run();
        test_async_reset();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfe_wait_scheduler.md
# cfe_wait_scheduler

Consumer end of the CFE feedback-wait interface. The block takes the wait time produced by the CFE wait-feedback logic and counts it down. It then fires a single-cycle start pulse to the carrier-frequency estimator (CFE) and waits for the estimator's result, with a timeout. Valid frequency-offset results are registered and returned as a one-cycle valid, which closes the feedback loop (scheduler → CFE → feedback → scheduler).

## Interface
- CFE_NBW_FO, 13: width of frequency-offset value
- CFE_NBW_LAT, 32: width of wait value
- CFE_TIMEOUT, 1024: max cycles in RUN awaiting CFE result (≥2)
- CFE_SETTLE, 2: cycles in HOLD before re-sampling i_wait (≥1; covers feedback update latency)
- clk  input  1  clock
- rst_async_n  input  1  asynchronous, active-low reset
- i_enable  input  1  level; scheduling active while high
- i_wait  input  CFE_NBW_LAT  wait cycles before next CFE start (unsigned)
- i_cfe_done  input  1  CFE result valid (single-cycle)
- i_fo_value  input  CFE_NBW_FO  CFE frequency offset, qualified by i_cfe_done
- o_cfe_start  output  1  single-cycle start pulse to CFE
- o_fo_valid  output  1  single-cycle, result forwarded (drives feedback i_valid)
- o_fo_value  output  CFE_NBW_FO  registered offset, held between updates
- o_timeout  output  1  single-cycle, CFE did not answer in time
- o_busy  output  1  high in RUN
- o_trig_cnt  output  16  number of start pulses issued, wraps
- o_tmo_cnt  output  16  number of timeouts, saturates at 0xFFFF

## Operation
- States: IDLE, WAIT, RUN, HOLD. All outputs are registered.
- Reset (async assert, sync release) clears state to IDLE, all counters to 0 and all outputs to 0.
- IDLE: if i_enable=1, load wait_cnt := max(i_wait,1) and go to WAIT.
- WAIT:
  - If wait_cnt>1, decrement.
  - If wait_cnt==1, set o_cfe_start:=1, tmo_cnt:=0, o_trig_cnt+=1 and go to RUN.
- RUN:
  - If i_cfe_done=1, set o_fo_value:=i_fo_value, o_fo_valid:=1, hold_cnt:=0 and go to HOLD.
  - Else if tmo_cnt==CFE_TIMEOUT-1, set o_timeout:=1, o_tmo_cnt+=1 (saturating), hold_cnt:=0 and go to HOLD.
  - Else increment tmo_cnt.
- HOLD:
  - Increment hold_cnt.
  - When hold_cnt==CFE_SETTLE-1, load wait_cnt := max(i_wait,1) and go to WAIT.
- i_enable=0 in any state moves to IDLE on the next edge.
  - Clears wait_cnt, tmo_cnt and hold_cnt; o_fo_value, o_trig_cnt and o_tmo_cnt are kept.
  - An in-flight RUN is abandoned with no timeout and no valid.
- i_cfe_done is ignored outside RUN. A late result after a timeout or disable is not forwarded.
- Simultaneous events:
  - i_cfe_done on the timeout edge: done wins, no o_timeout.
  - i_enable=0 on the same edge as i_cfe_done: disable wins, no o_fo_valid.
- i_wait is sampled only on IDLE→WAIT and HOLD→WAIT edges; changes at other times have no effect until the next sample.
- o_trig_cnt wraps 0xFFFF→0.

## Timing
- Enable sampled high at edge k, with N=max(i_wait,1): o_cfe_start is high for exactly the cycle after edge k+N.
- o_busy is high from edge k+N until the edge that leaves RUN.
- The earliest accepted i_cfe_done is at edge k+N+1. The last accepted is at edge k+N+CFE_TIMEOUT; the same edge without done raises o_timeout.
- Done sampled at edge e:
  - o_fo_valid/o_fo_value are visible after edge e.
  - i_wait is re-sampled at edge e+CFE_SETTLE.
  - The next o_cfe_start follows edge e+CFE_SETTLE+N'.
- Steady-state period = N' + CFE_SETTLE + response latency + 1 cycles.
- o_fo_valid, o_cfe_start and o_timeout never assert for more than one consecutive cycle. At most one of o_fo_valid and o_timeout is high per RUN.

## Test plan
- Basic loop:
  - Stimulus: reset, i_enable=1, i_wait=0x100, CFE responds 5 cycles after start with fo=0x0123.
  - Required: start 256 cycles after enable; o_fo_valid 1 cycle with o_fo_value=0x0123; next start 2+256 cycles after done edge; o_trig_cnt increments 1 per start.
- Zero/one wait:
  - Stimulus: i_wait=0, then i_wait=1.
  - Required: both give start one cycle after the WAIT entry edge.
- Timeout:
  - Stimulus: CFE_TIMEOUT=16, CFE never responds.
  - Required: o_timeout pulse 16 edges after entering RUN; o_tmo_cnt=1; o_fo_value unchanged. A later i_cfe_done during HOLD/WAIT is ignored.
- Done vs timeout:
  - Stimulus: i_cfe_done on edge k+N+CFE_TIMEOUT.
  - Required: o_fo_valid=1, o_timeout=0, o_tmo_cnt unchanged.
- Disable mid-RUN:
  - Stimulus: drop i_enable in RUN, with done on the same edge.
  - Required: IDLE, no o_fo_valid, o_busy=0 next cycle. Re-enable gives start after a fresh i_wait.
- Async reset mid-WAIT:
  - Stimulus: assert rst_async_n low between edges.
  - Required: all outputs 0 immediately; after release with i_enable=1, normal startup timing. Saturation check: force 0xFFFF timeouts, o_tmo_cnt stays 0xFFFF.
